// File: rtl/tick_monitor_pkg.sv
// Shared types for the tick interval monitor: FSM states and fault codes.
package tick_monitor_pkg;

    localparam int FCODE_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED,
        FAULT
    } state_t;

    typedef enum logic [FCODE_W-1:0] {
        NONE,
        EARLY,
        LATE,
        UPSTREAM
    } fault_code_t;

endpackage

// File: rtl/tick_monitor_if.sv
// Signal bundle between the delay stage / status logic and tick_monitor.
interface tick_monitor_if
    import tick_monitor_pkg::*;
#(
    parameter int CBITS    = 16,
    parameter int EVT_BITS = 8
);

    // No handshake: inputs are sampled on every rising clk edge, and every
    // output is a register that is valid continuously after reset.
    logic                tick_in;
    logic                upstream_err;
    logic                clear;
    logic                locked;
    logic                fault;
    logic [FCODE_W-1:0]  fault_code;
    logic [EVT_BITS-1:0] tick_count;
    logic [CBITS-1:0]    last_period;
    state_t              dbg_state;

    modport master (
        output tick_in, upstream_err, clear,
        input  locked, fault, fault_code, tick_count, last_period, dbg_state
    );

    modport slave (
        input  tick_in, upstream_err, clear,
        output locked, fault, fault_code, tick_count, last_period, dbg_state
    );

endinterface

// File: rtl/tick_interval_meter.sv
// Counts clocks since the last accepted tick and classifies the interval
// against the expected-period window.
module tick_interval_meter #(
    parameter int EXP_PERIOD = 25001,
    parameter int TOL        = 2,
    parameter int CBITS      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    output logic [CBITS-1:0] measured,
    output logic             good,
    output logic             early,
    output logic             late
);

    localparam logic [CBITS-1:0] WIN_LO = CBITS'(EXP_PERIOD - TOL);
    localparam logic [CBITS-1:0] WIN_HI = CBITS'(EXP_PERIOD + TOL);

    logic [CBITS-1:0] gap_cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            gap_cnt <= '0;
        end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + CBITS'(1);
        end
    end

    // measured counts the edge that carries the tick; hold at all-ones
    // once the counter has saturated so it never wraps back to small values.
    always_comb begin
        measured = (gap_cnt == '1) ? gap_cnt : gap_cnt + CBITS'(1);
        early    = measured < WIN_LO;
        late     = measured > WIN_HI;
        good     = !early && !late;
    end

endmodule

// File: rtl/tick_monitor.sv
// Tick interval monitor: locks onto a periodic tick and raises sticky
// early/late/upstream faults. Define TICK_MON_SVA_EN to compile in assertions.
module tick_monitor
    import tick_monitor_pkg::*;
#(
    parameter int EXP_PERIOD = 25001,
    parameter int TOL        = 2,
    parameter int CBITS      = 16,
    parameter int LOCK_CNT   = 3,
    parameter int EVT_BITS   = 8
) (
    input  logic          clk,
    input  logic          rst,
    tick_monitor_if.slave bus
);

    localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

    state_t              state;
    fault_code_t         code;
    logic [3:0]          good_cnt;
    logic                locked_r;
    logic                fault_r;
    logic [EVT_BITS-1:0] tick_count_r;
    logic [CBITS-1:0]    last_period_r;

    logic             acc_tick;
    logic [CBITS-1:0] measured;
    logic             good;
    logic             early;
    logic             late;

    // A tick coinciding with clear is dropped entirely.
    assign acc_tick = bus.tick_in && !bus.clear;

    tick_interval_meter #(
        .EXP_PERIOD (EXP_PERIOD),
        .TOL        (TOL),
        .CBITS      (CBITS)
    ) u_meter (
        .clk      (clk),
        .rst      (rst),
        .restart  (acc_tick || bus.clear),
        .measured (measured),
        .good     (good),
        .early    (early),
        .late     (late)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            code          <= NONE;
            good_cnt      <= '0;
            locked_r      <= 1'b0;
            fault_r       <= 1'b0;
            tick_count_r  <= '0;
            last_period_r <= '0;
        end else if (bus.clear) begin
            state    <= IDLE;
            code     <= NONE;
            good_cnt <= '0;
            locked_r <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            if (acc_tick) begin
                tick_count_r <= tick_count_r + EVT_BITS'(1);
                if (state != IDLE) begin
                    last_period_r <= measured;
                end
            end
            case (state)
                IDLE: begin
                    if (acc_tick) begin
                        state    <= TRACK;
                        good_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (acc_tick) begin
                        if (good) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == LOCK_N) begin
                                state    <= LOCKED;
                                locked_r <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end else if (late) begin
                        state    <= IDLE;
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    // Upstream error wins over a coincident early tick,
                    // which wins over an overdue tick.
                    if (bus.upstream_err || (acc_tick && early) || late) begin
                        state    <= FAULT;
                        locked_r <= 1'b0;
                        fault_r  <= 1'b1;
                        if (bus.upstream_err) begin
                            code <= UPSTREAM;
                        end else if (acc_tick && early) begin
                            code <= EARLY;
                        end else begin
                            code <= LATE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.locked      = locked_r;
    assign bus.fault       = fault_r;
    assign bus.fault_code  = code;
    assign bus.tick_count  = tick_count_r;
    assign bus.last_period = last_period_r;
    assign bus.dbg_state   = state;

`ifdef TICK_MON_SVA_EN
    a_fault_sticky: assert property (@(posedge clk) disable iff (rst)
        (fault_r && !bus.clear) |=> fault_r);

    a_code_iff_fault: assert property (@(posedge clk) disable iff (rst)
        ((code != NONE) == fault_r));

    a_lock_fault_excl: assert property (@(posedge clk) disable iff (rst)
        !(locked_r && fault_r));

    a_count_on_tick: assert property (@(posedge clk) disable iff (rst)
        !(bus.tick_in && !bus.clear) |=> $stable(tick_count_r));
`else
    // Assertions are compiled only when TICK_MON_SVA_EN is defined.
`endif

endmodule

// File: tb/tb_tick_monitor.sv
// Randomized and directed bench for tick_monitor with a time-stamp based
// reference model feeding an expected-output queue.
module tb_tick_monitor;
    import tick_monitor_pkg::*;

    localparam int EXP   = 10;
    localparam int TOL   = 1;
    localparam int LOCK  = 3;
    localparam int CBITS = 16;
    localparam int EVT   = 8;
    localparam int OW    = 4 + EVT + CBITS;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tick_monitor_if #(.CBITS(CBITS), .EVT_BITS(EVT)) bus ();

    tick_monitor #(
        .EXP_PERIOD (EXP),
        .TOL        (TOL),
        .CBITS      (CBITS),
        .LOCK_CNT   (LOCK),
        .EVT_BITS   (EVT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // scoreboard
    logic [OW-1:0] exp_q[$];
    string         ph_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    string         phase       = "init";

    // reference model: intervals are differences of absolute edge numbers
    int now_edge   = 0;
    int last_event = 0;
    int mode       = 0;  // 0 idle, 1 track, 2 locked, 3 fault
    int good_seen  = 0;
    int m_cnt      = 0;
    int m_lp       = 0;
    int m_locked   = 0;
    int m_fault    = 0;
    int m_code     = 0;

    task automatic model_step(input bit t, input bit u, input bit c, input bit r);
        int m;
        now_edge++;
        if (r) begin
            mode = 0; good_seen = 0; m_cnt = 0; m_lp = 0;
            m_locked = 0; m_fault = 0; m_code = 0; last_event = now_edge;
        end else if (c) begin
            mode = 0; good_seen = 0; m_locked = 0; m_fault = 0; m_code = 0;
            last_event = now_edge;
        end else begin
            m = now_edge - last_event;
            if (m > 65535) m = 65535;
            if (t) begin
                m_cnt = (m_cnt + 1) % 256;
                if (mode != 0) m_lp = m;
                last_event = now_edge;
            end
            if (mode == 0) begin
                if (t) begin mode = 1; good_seen = 0; end
            end else if (mode == 1) begin
                if (t) begin
                    if (m >= EXP - TOL && m <= EXP + TOL) begin
                        good_seen++;
                        if (good_seen == LOCK) begin mode = 2; m_locked = 1; end
                    end else begin
                        good_seen = 0;
                    end
                end else if (m > EXP + TOL) begin
                    mode = 0;
                end
            end else if (mode == 2) begin
                if (u || (t && m < EXP - TOL) || m > EXP + TOL) begin
                    mode = 3; m_locked = 0; m_fault = 1;
                    m_code = u ? 3 : ((t && m < EXP - TOL) ? 1 : 2);
                end
            end
        end
    endtask

    // driver tasks
    task automatic cyc(input bit t, input bit u, input bit c, input bit r);
        @(negedge clk);
        bus.tick_in      = t;
        bus.upstream_err = u;
        bus.clear        = c;
        rst              = r;
        model_step(t, u, c, r);
        exp_q.push_back({m_locked[0], m_fault[0], m_code[1:0], m_cnt[EVT-1:0], m_lp[CBITS-1:0]});
        ph_q.push_back(phase);
    endtask

    task automatic tick_after(input int p, input bit u);
        for (int k = 1; k < p; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, u, 1'b0, 1'b0);
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // monitor: one expected vector per clock edge
    initial begin
        logic [OW-1:0] e;
        logic [OW-1:0] a;
        string         p;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                p = ph_q.pop_front();
                a = {bus.locked, bus.fault, bus.fault_code, bus.tick_count, bus.last_period};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got lk=%0b f=%0b code=%0d tc=%0d lp=%0d, expected lk=%0b f=%0b code=%0d tc=%0d lp=%0d",
                             p, $time, a[OW-1], a[OW-2], a[OW-3:OW-4], a[EVT+CBITS-1:CBITS], a[CBITS-1:0],
                             e[OW-1], e[OW-2], e[OW-3:OW-4], e[EVT+CBITS-1:CBITS], e[CBITS-1:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int wait_cycles;
        bus.tick_in      = 1'b0;
        bus.upstream_err = 1'b0;
        bus.clear        = 1'b0;

        phase = "reset";
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        phase = "lock";
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick_after(10, 1'b0);
        idle(2);

        phase = "early";
        tick_after(6, 1'b0);
        idle(3);

        phase = "clear_tick";
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        tick_after(5, 1'b0);

        phase = "late";
        for (int i = 0; i < 3; i++) tick_after(10, 1'b0);
        idle(15);

        phase = "upstream";
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        tick_after(3, 1'b0);
        tick_after(10, 1'b1);
        tick_after(10, 1'b0);
        tick_after(10, 1'b0);
        tick_after(8, 1'b1);
        idle(2);

        phase = "track_timeout";
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        tick_after(2, 1'b0);
        tick_after(10, 1'b0);
        idle(14);
        tick_after(4, 1'b0);

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            int g;
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 70)      g = $urandom_range(EXP - TOL, EXP + TOL);
            else if (sel < 85) g = $urandom_range(EXP - 4, EXP - TOL - 1);
            else if (sel < 95) g = $urandom_range(EXP + TOL + 1, EXP + 4);
            else               g = $urandom_range(1, 3);
            for (int k = 1; k < g; k++)
                cyc(1'b0, $urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                    $urandom_range(0, 1999) == 0);
            cyc(1'b1, $urandom_range(0, 99) == 0,
                (m_fault != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 49) == 0, 1'b0);
        end
        idle(3);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
